// File: rtl/vs_arb_pkg.sv
// Shared types and constants for the VS10xx-style SCI/SDI bus arbiter.
// Optional SCI read support is enabled with VS_ARB_READ_EN.
package vs_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD_WAIT,
    CMD_SHIFT,
    DAT_SHIFT,
    GAP
  } state_t;

  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] REG_MODE = 8'h00;
  localparam logic [7:0] REG_VOL  = 8'h0B;

  localparam logic [5:0] CMD_BITS = 6'd32;
  localparam logic [5:0] DAT_BITS = 6'd8;

  // Reads clock out zeros after the address while SO is sampled
  function automatic logic [31:0] cmd_word(
    input logic        rd,
    input logic [7:0]  addr,
    input logic [15:0] data
  );
    return rd ? {OP_READ, addr, 16'h0000}
              : {OP_WRITE, addr, data};
  endfunction

endpackage

// File: rtl/vs_spi_shifter.sv
// SCK divider plus MSB-first shifter (mode 0) for up to 32 bits.
// With VS_ARB_READ_EN, SO is sampled on every SCK rising edge.
module vs_spi_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] data,
  input  logic [5:0]  nbits,
`ifdef VS_ARB_READ_EN
  input  logic        so,
  output logic [15:0] rx,
`endif
  output logic        sck,
  output logic        si,
  output logic        done
);

  localparam logic [8:0] RISE = 9'(CLK_DIV - 1);
  localparam logic [8:0] FALL = 9'(2 * CLK_DIV - 1);

  logic [30:0] sreg;
  logic [8:0]  div;
  logic [5:0]  bits;
  logic        active;

  assign done = active && (bits == 6'd1) && (div == FALL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg   <= '0;
      div    <= '0;
      bits   <= '0;
      active <= 1'b0;
      sck    <= 1'b0;
      si     <= 1'b0;
`ifdef VS_ARB_READ_EN
      rx     <= '0;
`endif
    end else if (load) begin
      sreg   <= data[30:0];
      si     <= data[31];
      div    <= '0;
      bits   <= nbits;
      active <= 1'b1;
      sck    <= 1'b0;
`ifdef VS_ARB_READ_EN
      rx     <= '0;
`endif
    end else if (active) begin
      if (div == FALL) begin
        div  <= '0;
        sck  <= 1'b0;
        bits <= bits - 6'd1;
        sreg <= {sreg[29:0], 1'b0};
        si   <= done ? 1'b0 : sreg[30];
        if (done) active <= 1'b0;
      end else begin
        div <= div + 9'd1;
        if (div == RISE) begin
          sck <= 1'b1;
`ifdef VS_ARB_READ_EN
          rx  <= {rx[14:0], so};
`endif
        end
      end
    end
  end

endmodule

// File: rtl/vs_bus_arbiter.sv
// Arbitrates SCI commands and SDI stream bytes onto a shared SPI bus.
// Define VS_ARB_READ_EN to add SCI register reads (i_cmd_rd/i_SO).
module vs_bus_arbiter
  import vs_arb_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int BURST_LEN  = 32,
  parameter int GAP_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_DREQ,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [7:0]  i_cmd_addr,
  input  logic [15:0] i_cmd_data,
`ifdef VS_ARB_READ_EN
  input  logic        i_cmd_rd,
  input  logic        i_SO,
  output logic [15:0] o_rd_data,
  output logic        o_rd_valid,
`endif
  input  logic        i_dat_valid,
  output logic        o_dat_ready,
  input  logic [7:0]  i_dat_byte,
  output logic        o_XCS,
  output logic        o_XDCS,
  output logic        o_SCK,
  output logic        o_SI,
  output logic        o_busy
);

  localparam logic [15:0] BURST_M1 = 16'(BURST_LEN - 1);
  localparam logic [7:0]  GAP_M1   = 8'(GAP_CYCLES - 1);

  state_t      state;
  logic        live;
  logic        fair;
  logic [15:0] burst;
  logic [7:0]  gap;
  logic [7:0]  addr;
  logic [15:0] data;
  logic        rd;

  logic        idle, fair_dat, dat_ok;
  logic        take_cmd, take_dat, cmd_go;
  logic        sh_load, sh_done;
  logic [31:0] sh_data;
  logic [5:0]  sh_bits;

  always_comb begin
    idle     = live && (state == IDLE);
    fair_dat = fair && i_dat_valid && i_DREQ;
    dat_ok   = i_dat_valid && (i_DREQ || (burst != '0));
    take_dat = idle && (fair_dat || (!i_cmd_valid && dat_ok));
    take_cmd = idle && i_cmd_valid && !fair_dat;
    cmd_go   = (state == CMD_WAIT) && i_DREQ;
    sh_load  = take_dat || cmd_go;
    sh_data  = take_dat ? {i_dat_byte, 24'h0}
                        : cmd_word(rd, addr, data);
    sh_bits  = take_dat ? DAT_BITS : CMD_BITS;
  end

  assign o_cmd_ready = take_cmd;
  assign o_dat_ready = take_dat;
  assign o_busy      = (state != IDLE);

`ifdef VS_ARB_READ_EN
  logic [15:0] sh_rx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd         <= 1'b0;
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= (state == CMD_SHIFT) && sh_done && rd;
      if (take_cmd) rd <= i_cmd_rd;
      if ((state == CMD_SHIFT) && sh_done && rd) o_rd_data <= sh_rx;
    end
  end
`else
  assign rd = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      live   <= 1'b0;
      fair   <= 1'b0;
      burst  <= '0;
      gap    <= '0;
      addr   <= '0;
      data   <= '0;
      o_XCS  <= 1'b1;
      o_XDCS <= 1'b1;
    end else begin
      live <= 1'b1;
      unique case (state)
        IDLE: begin
          if (take_cmd) begin
            addr  <= i_cmd_addr;
            data  <= i_cmd_data;
            burst <= '0;
            fair  <= 1'b0;
            state <= CMD_WAIT;
          end else if (take_dat) begin
            burst  <= (burst == '0) ? BURST_M1 : burst - 16'd1;
            fair   <= 1'b0;
            o_XDCS <= 1'b0;
            state  <= DAT_SHIFT;
          end
        end
        CMD_WAIT: begin
          if (i_DREQ) begin
            o_XCS <= 1'b0;
            state <= CMD_SHIFT;
          end
        end
        CMD_SHIFT: begin
          if (sh_done) begin
            o_XCS <= 1'b1;
            fair  <= 1'b1;
            gap   <= GAP_M1;
            state <= GAP;
          end
        end
        DAT_SHIFT: begin
          if (sh_done) begin
            o_XDCS <= 1'b1;
            gap    <= GAP_M1;
            state  <= GAP;
          end
        end
        GAP: begin
          if (gap == '0) state <= IDLE;
          else gap <= gap - 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  vs_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (sh_load),
    .data  (sh_data),
    .nbits (sh_bits),
`ifdef VS_ARB_READ_EN
    .so    (i_SO),
    .rx    (sh_rx),
`endif
    .sck   (o_SCK),
    .si    (o_SI),
    .done  (sh_done)
  );

endmodule
